// File: rtl/bram_pkg.sv
// Shared types and constants for the block-RAM controller: FSM state encoding,
// legal read-latency values and the address-width helper.
package bram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } bram_state_e;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bram_core.sv
// Single-port byte-enable memory array with a registered, read-first output.
// Read data holds its value whenever rd is low.
module bram_core #(
   parameter int DEPTH  = 3584,
   parameter int DATA_W = 32,
   parameter int AW     = 12
) (
   input  logic                clk,
   input  logic                wr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   din,
   input  logic                rd,
   output logic [DATA_W-1:0]   q
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Both updates are non-blocking, so a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (rd) q <= mem[addr];
      if (wr) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/bram_ctrl.sv
// Block-RAM controller: request acceptance, range check, read pipeline and
// optional post-reset clear sweep (enabled by defining BRAM_CTRL_CLEAR_EN).
//
// state    | meaning
// ST_CLEAR | zeroing one word per cycle at clr_ptr; requests ignored
// ST_IDLE  | accepting reads and writes
module bram_ctrl
   import bram_pkg::*;
#(
   parameter int BLOCKS   = 14,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 15,
   parameter int READ_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic                startReadRAM,
   output logic [DATA_W-1:0]   out,
   output logic                readRdyRAM,
   output logic                saveRdyRAM,
   output logic                err
);

   localparam int DEPTH   = BLOCKS * 256;
   localparam int CORE_AW = addr_bits(DEPTH);
   localparam int NB      = DATA_W / 8;
   localparam int LAT     = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   bram_state_e         state, state_nx;
   logic                save_rdy;
   logic                in_range, acc_wr, acc_rd;
   logic                core_wr, core_rd;
   logic [NB-1:0]       core_be;
   logic [CORE_AW-1:0]  core_addr;
   logic [DATA_W-1:0]   core_din, core_q;
   logic                v1, oor1, err_q;
   logic [DATA_W-1:0]   rd_sel, out_q;

   assign in_range = ({1'b0, addr} < DEPTH_L);
   assign acc_wr   = save_rdy & ~rst & we;
   assign acc_rd   = save_rdy & ~rst & startReadRAM;
   assign core_rd  = acc_rd & in_range;

`ifdef BRAM_CTRL_CLEAR_EN
   logic [CORE_AW-1:0] clr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      core_wr   = acc_wr & in_range;
      core_be   = be;
      core_addr = addr[CORE_AW-1:0];
      core_din  = din;
      if (state == ST_CLEAR) begin
         core_wr   = ~rst;
         core_be   = '1;
         core_addr = clr_ptr;
         core_din  = '0;
         if (clr_ptr == CORE_AW'(DEPTH - 1)) state_nx = ST_IDLE;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      core_wr   = acc_wr & in_range;
      core_be   = be;
      core_addr = addr[CORE_AW-1:0];
      core_din  = din;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) save_rdy <= 1'b0;
      else     save_rdy <= (state_nx == ST_IDLE);
   end

   bram_core #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (CORE_AW)
   ) u_core (
      .clk  (clk),
      .wr   (core_wr),
      .be   (core_be),
      .addr (core_addr),
      .din  (core_din),
      .rd   (core_rd),
      .q    (core_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         oor1  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         v1    <= acc_rd;
         oor1  <= ~in_range;
         err_q <= (acc_rd | acc_wr) & ~in_range;
      end
   end

   // Out-of-range reads never touch the core, so substitute zero here.
   assign rd_sel = oor1 ? '0 : core_q;

   if (LAT == READ_LAT_MIN) begin : g_lat1
      always_ff @(posedge clk) begin
         if (rst)     out_q <= '0;
         else if (v1) out_q <= rd_sel;
      end
      assign out        = (v1 & ~rst) ? rd_sel : out_q;
      assign readRdyRAM = v1 & ~rst;
   end else begin : g_lat2
      logic v2;
      always_ff @(posedge clk) begin
         if (rst) begin
            v2    <= 1'b0;
            out_q <= '0;
         end else begin
            v2 <= v1;
            if (v1) out_q <= rd_sel;
         end
      end
      assign out        = out_q;
      assign readRdyRAM = v2 & ~rst;
   end

   assign saveRdyRAM = save_rdy;
   assign err        = err_q & ~rst;

endmodule
